// File: rtl/transport_receive.sv
// Receive side of the transport packet layer: parses control and audio packets from the
// framed byte stream. Optional build macro RX_STRICT_CHECK_EN enforces padding/trailer values.
module transport_receive #(
    parameter int PACKET_SIZE = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_AW     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_byte,
    input  logic               rx_valid,
    input  logic               rx_frame,
    output logic [15:0]        ctrl_data,
    output logic               ctrl_valid,
    output logic [15:0]        audio_dout,
    input  logic               audio_rd_en,
    output logic               audio_empty,
    output logic [FIFO_AW:0]   audio_count,
    output logic               audio_overflow,
    output logic               pkt_err,
    output logic               busy
);
    localparam int CNT_W = $clog2(PACKET_SIZE + 1);
    localparam int FW    = FIFO_AW + 1;
    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(PACKET_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_LO_IDX = CNT_W'(PACKET_SIZE - 2);
    localparam logic [FW-1:0]    FIFO_FULL   = FW'(FIFO_DEPTH);
    localparam logic [7:0]       HDR_CTRL    = 8'h40;
    localparam logic [7:0]       HDR_AUDIO   = 8'h80;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CTRL_HI  = 3'd1,
        CTRL_LO  = 3'd2,
        CTRL_PAD = 3'd3,
        AUD_HI   = 3'd4,
        AUD_LO   = 3'd5,
        AUD_TRL  = 3'd6,
        DISCARD  = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         hi_q, hi_d;
    logic [15:0]        ctrl_data_q, ctrl_data_d;
    logic               ctrl_valid_q, ctrl_valid_d;
    logic               pkt_err_q, pkt_err_d;
    logic               overflow_q, overflow_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]      count_q, count_d;
    logic [15:0]        mem_q [FIFO_DEPTH];
    logic [15:0]        mem_d [FIFO_DEPTH];

    logic               acc_s, last_s, wr_req_s, rd_s, full_s, wr_s;
    logic [15:0]        wdata_s;
`ifdef RX_STRICT_CHECK_EN
    logic [7:0]         lo_q, lo_d;
    logic               pad_bad_q, pad_bad_d;
`endif

    assign acc_s   = rx_valid && rx_frame;
    assign last_s  = (cnt_q == LAST_IDX);
    assign wdata_s = {hi_q, rx_byte};

    // Packet parser: next state, byte counter and delivery decisions.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        ctrl_data_d  = ctrl_data_q;
        ctrl_valid_d = 1'b0;
        pkt_err_d    = 1'b0;
        wr_req_s     = 1'b0;
`ifdef RX_STRICT_CHECK_EN
        lo_d         = lo_q;
        pad_bad_d    = pad_bad_q;
`endif
        if ((state_q != IDLE) && !rx_frame) begin
            // Truncated packet; a discarded packet was already flagged at its header.
            state_d   = IDLE;
            cnt_d     = {CNT_W{1'b0}};
            pkt_err_d = (state_q != DISCARD);
        end else if (acc_s) begin
            cnt_d = last_s ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));
            case (state_q)
                IDLE: begin
                    cnt_d = CNT_W'(1);
`ifdef RX_STRICT_CHECK_EN
                    pad_bad_d = 1'b0;
`endif
                    if (rx_byte == HDR_CTRL) begin
                        state_d = CTRL_HI;
                    end else if (rx_byte == HDR_AUDIO) begin
                        state_d = AUD_HI;
                    end else begin
                        state_d   = DISCARD;
                        pkt_err_d = 1'b1;
                    end
                end
                CTRL_HI: begin
                    hi_d    = rx_byte;
                    state_d = CTRL_LO;
                end
                CTRL_LO: begin
                    state_d = CTRL_PAD;
`ifdef RX_STRICT_CHECK_EN
                    lo_d = rx_byte;
`else
                    ctrl_data_d  = wdata_s;
                    ctrl_valid_d = 1'b1;
`endif
                end
                CTRL_PAD: begin
`ifdef RX_STRICT_CHECK_EN
                    pad_bad_d = pad_bad_q | (rx_byte != 8'h00);
                    if (last_s) begin
                        state_d = IDLE;
                        if (pad_bad_d) begin
                            pkt_err_d = 1'b1;
                        end else begin
                            ctrl_data_d  = {hi_q, lo_q};
                            ctrl_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = CTRL_PAD;
                    end
`else
                    state_d = last_s ? IDLE : CTRL_PAD;
`endif
                end
                AUD_HI: begin
                    hi_d    = rx_byte;
                    state_d = AUD_LO;
                end
                AUD_LO: begin
                    wr_req_s = 1'b1;
                    state_d  = (cnt_q == LAST_LO_IDX) ? AUD_TRL : AUD_HI;
                end
                AUD_TRL: begin
                    state_d = IDLE;
`ifdef RX_STRICT_CHECK_EN
                    pkt_err_d = (rx_byte != 8'hFF);
`endif
                end
                DISCARD: begin
                    state_d = last_s ? IDLE : DISCARD;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Sample FIFO: a write on full only succeeds when a read frees the head slot.
    always_comb begin
        rd_s       = audio_rd_en && (count_q != {FW{1'b0}});
        full_s     = (count_q == FIFO_FULL);
        wr_s       = wr_req_s && (!full_s || rd_s);
        overflow_d = overflow_q | (wr_req_s & full_s & ~rd_s);
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(wr_s);
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(rd_s);
        count_d    = count_q + FW'(wr_s) - FW'(rd_s);
        mem_d      = mem_q;
        mem_d[wr_ptr_q] = wr_s ? wdata_s : mem_q[wr_ptr_q];
    end

    // Parser and FIFO control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            hi_q         <= 8'h00;
            ctrl_data_q  <= 16'h0000;
            ctrl_valid_q <= 1'b0;
            pkt_err_q    <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= {FIFO_AW{1'b0}};
            rd_ptr_q     <= {FIFO_AW{1'b0}};
            count_q      <= {FW{1'b0}};
`ifdef RX_STRICT_CHECK_EN
            lo_q         <= 8'h00;
            pad_bad_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            ctrl_data_q  <= ctrl_data_d;
            ctrl_valid_q <= ctrl_valid_d;
            pkt_err_q    <= pkt_err_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
`ifdef RX_STRICT_CHECK_EN
            lo_q         <= lo_d;
            pad_bad_q    <= pad_bad_d;
`endif
        end
    end

    // Sample storage needs no reset; occupancy is defined by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ctrl_data      = ctrl_data_q;
    assign ctrl_valid     = ctrl_valid_q;
    assign pkt_err        = pkt_err_q;
    assign audio_overflow = overflow_q;
    assign audio_count    = count_q;
    assign audio_empty    = (count_q == {FW{1'b0}});
    assign audio_dout     = mem_q[rd_ptr_q];
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_transport_receive.sv
// Bench for transport_receive: directed packets plus randomized packet streams checked
// against a packet-level reference model (expected control word, sample queue, pulse counts).
module tb_transport_receive;
    localparam int PS    = 16;
    localparam int DEPTH = 16;
    localparam int NSAMP = (PS - 2) / 2;

    logic        clk = 1'b0;
    logic        reset, rx_valid, rx_frame, audio_rd_en;
    logic [7:0]  rx_byte;
    logic [15:0] ctrl_data, audio_dout;
    logic        ctrl_valid, audio_empty, audio_overflow, pkt_err, busy;
    logic [4:0]  audio_count;

    transport_receive #(.PACKET_SIZE(PS), .FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_frame(rx_frame),
        .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid), .audio_dout(audio_dout),
        .audio_rd_en(audio_rd_en), .audio_empty(audio_empty), .audio_count(audio_count),
        .audio_overflow(audio_overflow), .pkt_err(pkt_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_mis = 0;
    int          n_cv = 0, n_err = 0;
    int          exp_cv = 0, exp_err = 0;
    logic [15:0] exp_ctrl = 16'h0000;
    logic        exp_ovf = 1'b0;
    logic [15:0] exp_q[$];
    logic [7:0]  pkt [PS];
    int          pop_byte = -1;
    bit          gaps = 1'b0;
    int          cv_at;

    // Pulse monitor: each one-cycle pulse is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (ctrl_valid) n_cv++;
            if (pkt_err) n_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic build_ctrl(input logic [15:0] d);
        pkt[0] = 8'h40;
        pkt[1] = d[15:8];
        pkt[2] = d[7:0];
        for (int i = 3; i < PS; i++) pkt[i] = 8'h00;
    endtask

    task automatic build_audio(input logic [15:0] base, input bit rnd);
        logic [15:0] smp;
        pkt[0] = 8'h80;
        for (int s = 0; s < NSAMP; s++) begin
            smp = rnd ? 16'($urandom) : (base + 16'(s));
            pkt[2*s+1] = smp[15:8];
            pkt[2*s+2] = smp[7:0];
        end
        pkt[PS-1] = 8'hFF;
    endtask

    // Reference model: effect of one packet of which the first cut bytes arrived.
    task automatic model_pkt(input int cut, input int pop_s);
        logic        ok;
        int          ns;
        logic [15:0] tmp;
        if (cut == 0) return;
        if (pkt[0] == 8'h40) begin
            if (cut < PS) begin
                exp_err++;
`ifndef RX_STRICT_CHECK_EN
                if (cut >= 3) begin
                    exp_ctrl = {pkt[1], pkt[2]};
                    exp_cv++;
                end
`endif
            end else begin
                ok = 1'b1;
`ifdef RX_STRICT_CHECK_EN
                for (int i = 3; i < PS; i++) if (pkt[i] != 8'h00) ok = 1'b0;
`endif
                if (ok) begin
                    exp_ctrl = {pkt[1], pkt[2]};
                    exp_cv++;
                end else begin
                    exp_err++;
                end
            end
        end else if (pkt[0] == 8'h80) begin
            ns = (cut >= PS) ? NSAMP : (cut - 1) / 2;
            for (int s = 0; s < ns; s++) begin
                if (s == pop_s && exp_q.size() > 0) tmp = exp_q.pop_front();
                if (exp_q.size() < DEPTH) exp_q.push_back({pkt[2*s+1], pkt[2*s+2]});
                else exp_ovf = 1'b1;
            end
            if (cut < PS) exp_err++;
`ifdef RX_STRICT_CHECK_EN
            else if (pkt[PS-1] != 8'hFF) exp_err++;
`endif
        end else begin
            exp_err++;
        end
    endtask

    // Drive the first cut bytes of pkt; keep leaves the frame up for a back-to-back packet.
    task automatic send_pkt(input int cut, input bit keep);
        cv_at = -1;
        for (int i = 0; i < cut; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_byte  = 8'($urandom);
            end
            @(negedge clk);
            if (ctrl_valid) cv_at = i - 1;
            if (i == 1) chk("busy_mid", {31'd0, busy}, 32'd1);
            rx_byte     = pkt[i];
            rx_valid    = 1'b1;
            rx_frame    = 1'b1;
            audio_rd_en = (i == pop_byte);
        end
        if (!keep) begin
            @(negedge clk);
            if (ctrl_valid) cv_at = cut - 1;
            if (cut == PS) chk("busy_end", {31'd0, busy}, 32'd0);
            audio_rd_en = 1'b0;
            rx_valid    = 1'b0;
            rx_frame    = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ctrl_data"}, {16'd0, ctrl_data}, {16'd0, exp_ctrl});
        chk({tag, "_ctrl_pulses"}, n_cv, exp_cv);
        chk({tag, "_err_pulses"}, n_err, exp_err);
        chk({tag, "_count"}, {27'd0, audio_count}, exp_q.size());
        chk({tag, "_empty"}, {31'd0, audio_empty}, {31'd0, (exp_q.size() == 0)});
        chk({tag, "_overflow"}, {31'd0, audio_overflow}, {31'd0, exp_ovf});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic pops(input int k);
        logic [15:0] tmp;
        for (int j = 0; j < k; j++) begin
            @(negedge clk);
            chk("pop_head", {16'd0, audio_dout}, {16'd0, exp_q[0]});
            audio_rd_en = 1'b1;
            tmp = exp_q.pop_front();
        end
        @(negedge clk);
        audio_rd_en = 1'b0;
        chk("pop_count", {27'd0, audio_count}, exp_q.size());
    endtask

    initial begin
        int        kind, cut;
        bit        keep;
        logic [7:0] h;
        reset = 1'b1; rx_valid = 1'b0; rx_frame = 1'b0; rx_byte = 8'h00; audio_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl_data", {16'd0, ctrl_data}, 32'd0);
        chk("rst_ctrl_valid", {31'd0, ctrl_valid}, 32'd0);
        chk("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, audio_overflow}, 32'd0);
        chk("rst_empty", {31'd0, audio_empty}, 32'd1);
        chk("rst_count", {27'd0, audio_count}, 32'd0);
        reset = 1'b0;

        // Control packet 40 12 34 + zero padding
        build_ctrl(16'h1234);
        send_pkt(PS, 1'b0); model_pkt(PS, -1);
`ifdef RX_STRICT_CHECK_EN
        chk("ctrl_valid_cycle", cv_at, PS - 1);
`else
        chk("ctrl_valid_cycle", cv_at, 2);
`endif
        check_state("ctrl1");

        // Audio packet with samples 0001..0007
        build_audio(16'h0001, 1'b0);
        send_pkt(PS, 1'b0); model_pkt(PS, -1);
        check_state("aud1");
        pops(7);
        chk("aud1_drained", {31'd0, audio_empty}, 32'd1);

        // Bad header then a back-to-back valid control packet
        pkt[0] = 8'h55;
        for (int i = 1; i < PS; i++) pkt[i] = 8'($urandom);
        send_pkt(PS, 1'b1); model_pkt(PS, -1);
        build_ctrl(16'hC0DE);
        send_pkt(PS, 1'b0); model_pkt(PS, -1);
        check_state("badhdr");

        // Control packet truncated after 40 AB, then a normal packet
        build_ctrl(16'hAB00);
        send_pkt(2, 1'b0); model_pkt(2, -1);
        check_state("trunc");
        build_ctrl(16'h5A5A);
        send_pkt(PS, 1'b0); model_pkt(PS, -1);
        check_state("after_trunc");

        // A byte offered with rx_frame low is ignored
        @(negedge clk); rx_valid = 1'b1; rx_frame = 1'b0; rx_byte = 8'h40;
        @(negedge clk); rx_valid = 1'b0;
        chk("noframe_busy", {31'd0, busy}, 32'd0);

        // Three back-to-back audio packets overflow the FIFO
        build_audio(16'h1000, 1'b0); send_pkt(PS, 1'b1); model_pkt(PS, -1);
        build_audio(16'h2000, 1'b0); send_pkt(PS, 1'b1); model_pkt(PS, -1);
        build_audio(16'h3000, 1'b0); send_pkt(PS, 1'b0); model_pkt(PS, -1);
        check_state("overflow");
        // Read coincides with the first sample write while full
        build_audio(16'h4000, 1'b0);
        pop_byte = 2;
        send_pkt(PS, 1'b0); model_pkt(PS, 0);
        pop_byte = -1;
        check_state("full_rdwr");
        pops(exp_q.size());

        // Read while empty is ignored
        @(negedge clk); audio_rd_en = 1'b1;
        @(negedge clk); audio_rd_en = 1'b0;
        chk("empty_read_count", {27'd0, audio_count}, 32'd0);
        chk("empty_read_empty", {31'd0, audio_empty}, 32'd1);

        // Nonzero padding byte and bad trailer
        build_ctrl(16'hBEEF); pkt[9] = 8'h01;
        send_pkt(PS, 1'b0); model_pkt(PS, -1);
        check_state("bad_pad");
        build_audio(16'h0100, 1'b0); pkt[PS-1] = 8'hFE;
        send_pkt(PS, 1'b0); model_pkt(PS, -1);
        check_state("bad_trailer");

        // Reset in the middle of an audio packet abandons it
        build_audio(16'h0200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); rx_byte = pkt[i]; rx_valid = 1'b1; rx_frame = 1'b1;
        end
        @(negedge clk); reset = 1'b1; rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b0; rx_frame = 1'b0;
        exp_q.delete(); exp_ctrl = 16'h0000; exp_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_state("mid_reset");

        // Randomized packet stream with gaps, truncations and back-to-back packets
        gaps = 1'b1;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 4);
            if (kind <= 1) begin
                build_ctrl(16'($urandom));
                if ($urandom_range(0, 3) == 0) pkt[$urandom_range(3, PS-1)] = 8'($urandom_range(1, 255));
            end else if (kind <= 3) begin
                build_audio(16'h0000, 1'b1);
                if ($urandom_range(0, 3) == 0) pkt[PS-1] = 8'($urandom_range(0, 254));
            end else begin
                do h = 8'($urandom); while (h == 8'h40 || h == 8'h80);
                pkt[0] = h;
                for (int i = 1; i < PS; i++) pkt[i] = 8'($urandom);
            end
            cut = PS;
            if (kind != 4 && $urandom_range(0, 4) == 0) cut = $urandom_range(1, PS - 1);
            keep = (cut == PS) && ($urandom_range(0, 2) == 0) && (n < 79);
            send_pkt(cut, keep);
            model_pkt(cut, -1);
            if (!keep) begin
                check_state("rnd");
                pops($urandom_range(0, exp_q.size()));
            end
        end
        pops(exp_q.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
